// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester pulses, responses and the byte-wide RAM port.
// slave = controller side, master = requesters/RAM side.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;
  logic              in_fetch_ce;
  logic [ADDR_W-1:0] in_fetch_addr;
  logic              out_fetch_ce;
  logic [31:0]       out_fetch_instr;
  logic              in_lsb_ce;
  logic              in_lsb_wr;
  logic [ADDR_W-1:0] in_lsb_addr;
  logic [1:0]        in_lsb_size;
  logic [31:0]       in_lsb_data;
  logic              out_lsb_ce;
  logic [31:0]       out_lsb_data;
  logic              in_rob_misbranch;

  modport slave (
    input  rdy,
    input  mem_din,
    input  io_buffer_full,
    input  in_fetch_ce,
    input  in_fetch_addr,
    input  in_lsb_ce,
    input  in_lsb_wr,
    input  in_lsb_addr,
    input  in_lsb_size,
    input  in_lsb_data,
    input  in_rob_misbranch,
    output mem_dout,
    output mem_a,
    output mem_wr,
    output out_fetch_ce,
    output out_fetch_instr,
    output out_lsb_ce,
    output out_lsb_data
  );

  modport master (
    output rdy,
    output mem_din,
    output io_buffer_full,
    output in_fetch_ce,
    output in_fetch_addr,
    output in_lsb_ce,
    output in_lsb_wr,
    output in_lsb_addr,
    output in_lsb_size,
    output in_lsb_data,
    output in_rob_misbranch,
    input  mem_dout,
    input  mem_a,
    input  mem_wr,
    input  out_fetch_ce,
    input  out_fetch_instr,
    input  out_lsb_ce,
    input  out_lsb_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch and load/store requests onto a byte RAM.
// LSB wins over fetch; one byte per cycle, little-endian assembly.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE
  } state_t;

  state_t state;
  state_t state_n;

  logic [2:0]        k;
  logic [2:0]        cur_n;
  logic              cur_f;
  logic [ADDR_W-1:0] cur_a;
  logic [31:0]       cur_d;
  logic [31:0]       rbuf;

  logic              pf_v;
  logic [ADDR_W-1:0] pf_a;
  logic              pl_v;
  logic              pl_wr;
  logic [ADDR_W-1:0] pl_a;
  logic [1:0]        pl_sz;
  logic [31:0]       pl_d;

  logic        f_ce;
  logic        l_ce;
  logic [31:0] f_dat;
  logic [31:0] l_dat;

  logic              f_v;
  logic              l_v;
  logic              l_wr;
  logic              io_blk;
  logic [ADDR_W-1:0] f_a;
  logic [ADDR_W-1:0] l_a;
  logic [1:0]        l_sz;
  logic [2:0]        l_n;
  logic [31:0]       l_d;
  logic              start_f;
  logic              start_l;
  logic              fin;
  logic              abort;
  logic [1:0]        bidx;
  logic [31:0]       rbuf_n;

  // request view: pending slot if full, else this cycle's pulse
  always_comb begin
    f_v  = ~bus.in_rob_misbranch
         & (pf_v | bus.in_fetch_ce);
    f_a  = pf_v ? pf_a : bus.in_fetch_addr;
    l_v  = pl_v | bus.in_lsb_ce;
    l_wr = pl_v ? pl_wr : bus.in_lsb_wr;
    l_a  = pl_v ? pl_a : bus.in_lsb_addr;
    l_sz = pl_v ? pl_sz : bus.in_lsb_size;
    l_d  = pl_v ? pl_d : bus.in_lsb_data;
    l_n  = 3'd4;
    unique case (1'b1)
      l_sz == 2'b00: l_n = 3'd1;
      l_sz == 2'b01: l_n = 3'd2;
      default:       l_n = 3'd4;
    endcase
    io_blk = l_wr & (&l_a[17:16])
           & bus.io_buffer_full;
  end

  // next state and transfer control strobes
  always_comb begin
    state_n = state;
    start_f = 1'b0;
    start_l = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (l_v) begin
          if (!io_blk) begin
            start_l = 1'b1;
            state_n = l_wr ? WRITE : READ;
          end
        end else if (f_v) begin
          start_f = 1'b1;
          state_n = READ;
        end
      end
      READ: begin
        if (cur_f && bus.in_rob_misbranch) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (k == cur_n) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
      WRITE: begin
        if (k == cur_n - 3'd1) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // RAM port: address/data only while a byte is being issued
  always_comb begin
    bus.mem_a    = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = 8'd0;
    bidx         = k[1:0] - 2'd1;
    rbuf_n       = rbuf;
    rbuf_n[{bidx, 3'b000} +: 8] = bus.mem_din;
    if ((state == READ && k != cur_n) ||
        state == WRITE)
      bus.mem_a = cur_a + ADDR_W'(k);
    if (state == WRITE) begin
      bus.mem_wr   = 1'b1;
      bus.mem_dout = cur_d[{k[1:0], 3'b000} +: 8];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else if (bus.rdy)
      state <= state_n;
  end

  // pending slots, transfer datapath and response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_v  <= 1'b0;
      pf_a  <= '0;
      pl_v  <= 1'b0;
      pl_wr <= 1'b0;
      pl_a  <= '0;
      pl_sz <= 2'd0;
      pl_d  <= 32'd0;
      k     <= 3'd0;
      cur_n <= 3'd0;
      cur_f <= 1'b0;
      cur_a <= '0;
      cur_d <= 32'd0;
      rbuf  <= 32'd0;
      f_ce  <= 1'b0;
      l_ce  <= 1'b0;
      f_dat <= 32'd0;
      l_dat <= 32'd0;
    end else if (bus.rdy) begin
      f_ce <= 1'b0;
      l_ce <= 1'b0;
      if (bus.in_rob_misbranch || start_f) begin
        pf_v <= 1'b0;
      end else if (bus.in_fetch_ce) begin
        pf_v <= 1'b1;
        pf_a <= bus.in_fetch_addr;
      end
      if (start_l) begin
        pl_v <= 1'b0;
      end else if (bus.in_lsb_ce) begin
        pl_v  <= 1'b1;
        pl_wr <= bus.in_lsb_wr;
        pl_a  <= bus.in_lsb_addr;
        pl_sz <= bus.in_lsb_size;
        pl_d  <= bus.in_lsb_data;
      end
      if (start_l) begin
        cur_a <= l_a;
        cur_n <= l_n;
        cur_d <= l_d;
        cur_f <= 1'b0;
        k     <= 3'd0;
        rbuf  <= 32'd0;
      end else if (start_f) begin
        cur_a <= f_a;
        cur_n <= 3'd4;
        cur_f <= 1'b1;
        k     <= 3'd0;
        rbuf  <= 32'd0;
      end else if (state == READ && !abort) begin
        if (k != 3'd0)
          rbuf <= rbuf_n;
        if (k != cur_n)
          k <= k + 3'd1;
        if (fin && cur_f) begin
          f_ce  <= 1'b1;
          f_dat <= rbuf_n;
        end else if (fin) begin
          l_ce  <= 1'b1;
          l_dat <= rbuf_n;
        end
      end else if (state == WRITE) begin
        k <= k + 3'd1;
        if (fin) begin
          l_ce  <= 1'b1;
          l_dat <= 32'd0;
        end
      end
    end
  end

  assign bus.out_fetch_ce    = f_ce;
  assign bus.out_fetch_instr = f_dat;
  assign bus.out_lsb_ce      = l_ce;
  assign bus.out_lsb_data    = l_dat;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all byte addresses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rdy  input  1  global enable; when low, all state and outputs hold.
REQ-005 SHALL have port mem_din  input  8  RAM read byte.
REQ-006 SHALL have port mem_dout  output  8  RAM write byte.
REQ-007 SHALL have port mem_a  output  ADDR_W  RAM byte address.
REQ-008 SHALL have port mem_wr  output  1  RAM write strobe: 1 = write, 0 = read.
REQ-009 SHALL have port io_buffer_full  input  1  I/O output buffer full.
REQ-010 SHALL have ports in_fetch_ce  input  1  and in_fetch_addr  input  ADDR_W: one-cycle pulse requesting a 4-byte instruction read.
REQ-011 SHALL have ports out_fetch_ce  output  1  and out_fetch_instr  output  32: one-cycle instruction-return pulse plus data.
REQ-012 SHALL have ports in_lsb_ce  input  1, in_lsb_wr  input  1, in_lsb_addr  input  ADDR_W, in_lsb_size  input  2 (00 = 1 B, 01 = 2 B, 10 = 4 B), in_lsb_data  input  32: one-cycle load/store request pulse.
REQ-013 SHALL have ports out_lsb_ce  output  1  and out_lsb_data  output  32: one-cycle completion pulse plus zero-extended load data (0 for stores).
REQ-014 SHALL have port in_rob_misbranch  input  1  pipeline flush.

Function
REQ-015 SHALL latch each request pulse into a per-requester pending register (addr, size, wr, data); at most one pending request per requester; a new pulse while one is pending is a protocol error and need not be handled.
REQ-016 SHALL have states IDLE, READ and WRITE; from IDLE, a pending LSB request SHALL win over a pending fetch; a pending request SHALL start no earlier than the cycle after its pulse.
REQ-017 SHALL keep the losing request pending and service it directly after the current transfer returns to IDLE; there is no pre-emption mid-transfer.
REQ-018 READ: N bytes (N = 4 for fetch, 1/2/4 for LSB); drive mem_a = addr+k, mem_wr = 0 for k = 0..N-1 on consecutive cycles; the byte for address addr+k is valid on mem_din one cycle after it is driven and SHALL be placed at bits [8k+7:8k] (little-endian).
REQ-019 READ SHALL pulse out_*_ce with the assembled data in the cycle after the last byte is captured; total request-pulse-to-response latency = N+2 cycles.
REQ-020 WRITE: drive mem_a = addr+k, mem_dout = in_lsb_data[8k+7:8k], mem_wr = 1 for k = 0..N-1 on consecutive cycles; pulse out_lsb_ce the cycle after the last byte; latency N+1 cycles.
REQ-021 A write with addr[17:16] = 2'b11 (I/O) SHALL not start, and SHALL stay pending with mem_wr = 0, while io_buffer_full = 1; during the stall no other request is served.
REQ-022 In IDLE and between transfers, mem_wr = 0, mem_a = 0 and mem_dout = 0.
REQ-023 On in_rob_misbranch = 1: the pending fetch is cleared; an in-flight fetch read is aborted to IDLE next cycle with no out_fetch_ce; a fetch pulse in the same cycle is discarded; LSB pending and in-flight transfers are unaffected.
REQ-024 out_fetch_ce and out_lsb_ce SHALL each be high for exactly one cycle per completed request and are never high together.
REQ-025 Address arithmetic addr+k SHALL wrap modulo 2^ADDR_W.
REQ-026 When rdy = 0, no counter, state, pending register or output changes; request pulses arriving while rdy = 0 are ignored.

Reset
REQ-027 With rst = 1 at a clock edge: state = IDLE, both pending flags cleared, any transfer aborted, and all outputs = 0, regardless of rdy.

Verification
REQ-028 Fetch at 0x00001000, RAM holds bytes 13 05 00 00 -> out_fetch_instr = 0x00000513 with out_fetch_ce 6 cycles after the pulse, mem_wr = 0 throughout.
REQ-029 Simultaneous fetch 0x0 and LSB 2-byte load 0x100 (RAM AA BB) -> out_lsb_ce with out_lsb_data = 0x0000BBAA first, fetch response afterwards with correct data.
REQ-030 LSB 4-byte store 0xDEADBEEF to 0x200 -> mem_a 0x200..0x203 with mem_dout EF, BE, AD, DE and mem_wr = 1 on 4 consecutive cycles; out_lsb_ce 5 cycles after the pulse.
REQ-031 1-byte store to 0x30000 with io_buffer_full = 1 for 10 cycles -> no mem_wr for those 10 cycles; the write issues once io_buffer_full drops; a fetch pending meanwhile is served only afterwards.
REQ-032 Misbranch during the third byte of a fetch -> no out_fetch_ce, state returns to IDLE, and a following fetch completes normally.
REQ-033 rst asserted mid-write, and rdy = 0 held for 3 cycles mid-read -> reset: all outputs 0 next cycle; rdy stall: outputs frozen and response delayed by exactly 3 cycles.
